// File: rtl/fig_04b_block_075_reg_select.sv
// Register-file write sequencer: tracks SuperFX prefix state (Sreg/Dreg/B), resolves MOVE/MOVES,
// assembles IBT/IWT immediates and arbitrates the single registered write port.
module fig_04b_block_075_reg_select (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [7:0]  opcode,
  input  logic        alt_mem,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        result_valid,
  input  logic [15:0] result,
  input  logic [15:0] rs_data,
  output logic [3:0]  src_sel,
  output logic [3:0]  sreg,
  output logic [3:0]  dreg,
  output logic        b_flag,
  output logic [15:0] z,
  output logic [3:0]  zsel,
  output logic        enable,
  output logic        busy,
  output logic        collision
);

  typedef enum logic [1:0] {IDLE = 2'd0, IMM_LO = 2'd1, IMM_HI = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [3:0]  sreg_r, sreg_s, dreg_r, dreg_s;
  logic [3:0]  wb_dst_r, wb_dst_s, imm_dst_r, imm_dst_s;
  logic        b_flag_r, b_flag_s, iwt_r, iwt_s;
  logic [7:0]  lo_r, lo_s;
  logic        accept_s, mv_req_s, imm_req_s;
  logic [3:0]  mv_dst_s;
  logic [15:0] imm_data_s;
  logic        wr_s, coll_s;
  logic [3:0]  wr_sel_s;
  logic [15:0] wr_data_s;
  logic [15:0] z_r;
  logic [3:0]  zsel_r;
  logic        enable_r, collision_r;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  assign accept_s = op_valid && (state_r == IDLE);

  // MOVES reads the register named in the opcode; everything else reads Sreg
  always_comb begin
    if (op_valid && (opcode[7:4] == 4'hB) && b_flag_r) begin
      src_sel = opcode[3:0];
    end else begin
      src_sel = sreg_r;
    end
  end

  // Opcode decode, prefix tracking and immediate-byte sequencing
  always_comb begin
    state_s    = state_r;
    sreg_s     = sreg_r;
    dreg_s     = dreg_r;
    b_flag_s   = b_flag_r;
    wb_dst_s   = wb_dst_r;
    imm_dst_s  = imm_dst_r;
    iwt_s      = iwt_r;
    lo_s       = lo_r;
    mv_req_s   = 1'b0;
    mv_dst_s   = 4'd0;
    imm_req_s  = 1'b0;
    imm_data_s = 16'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (opcode[7:4])
            4'h1: begin
              if (b_flag_r) begin
                mv_req_s = 1'b1;
                mv_dst_s = opcode[3:0];
                sreg_s   = 4'd0;
                dreg_s   = 4'd0;
                b_flag_s = 1'b0;
              end else begin
                dreg_s = opcode[3:0];
              end
            end
            4'h2: begin
              sreg_s   = opcode[3:0];
              dreg_s   = opcode[3:0];
              b_flag_s = 1'b1;
            end
            4'hB: begin
              if (b_flag_r) begin
                mv_req_s = 1'b1;
                mv_dst_s = dreg_r;
                sreg_s   = 4'd0;
                dreg_s   = 4'd0;
                b_flag_s = 1'b0;
              end else begin
                sreg_s = opcode[3:0];
              end
            end
            4'hA, 4'hF: begin
              if (!alt_mem) begin
                imm_dst_s = opcode[3:0];
                iwt_s     = (opcode[7:4] == 4'hF);
                state_s   = IMM_LO;
              end else begin
                wb_dst_s = dreg_r;
              end
              sreg_s   = 4'd0;
              dreg_s   = 4'd0;
              b_flag_s = 1'b0;
            end
            default: begin
              wb_dst_s = dreg_r;
              sreg_s   = 4'd0;
              dreg_s   = 4'd0;
              b_flag_s = 1'b0;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      IMM_LO: begin
        if (byte_valid) begin
          if (iwt_r) begin
            lo_s    = byte_in;
            state_s = IMM_HI;
          end else begin
            imm_req_s  = 1'b1;
            imm_data_s = sext8(byte_in);
            state_s    = IDLE;
          end
        end else begin
          state_s = IMM_LO;
        end
      end
      IMM_HI: begin
        if (byte_valid) begin
          imm_req_s  = 1'b1;
          imm_data_s = {byte_in, lo_r};
          state_s    = IDLE;
        end else begin
          state_s = IMM_HI;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Write arbitration: ALU result beats immediate completion beats MOVE/MOVES
  always_comb begin
    wr_s      = 1'b0;
    coll_s    = 1'b0;
    wr_sel_s  = 4'd0;
    wr_data_s = 16'd0;
    if (result_valid) begin
      wr_s      = 1'b1;
      wr_sel_s  = wb_dst_r;
      wr_data_s = result;
      coll_s    = imm_req_s || mv_req_s;
    end else if (imm_req_s) begin
      wr_s      = 1'b1;
      wr_sel_s  = imm_dst_r;
      wr_data_s = imm_data_s;
      coll_s    = mv_req_s;
    end else if (mv_req_s) begin
      wr_s      = 1'b1;
      wr_sel_s  = mv_dst_s;
      wr_data_s = rs_data;
    end else begin
      wr_s = 1'b0;
    end
  end

  // State and registered write-port update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      sreg_r      <= 4'd0;
      dreg_r      <= 4'd0;
      b_flag_r    <= 1'b0;
      wb_dst_r    <= 4'd0;
      imm_dst_r   <= 4'd0;
      iwt_r       <= 1'b0;
      lo_r        <= 8'd0;
      z_r         <= 16'd0;
      zsel_r      <= 4'd0;
      enable_r    <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sreg_r      <= sreg_s;
      dreg_r      <= dreg_s;
      b_flag_r    <= b_flag_s;
      wb_dst_r    <= wb_dst_s;
      imm_dst_r   <= imm_dst_s;
      iwt_r       <= iwt_s;
      lo_r        <= lo_s;
      enable_r    <= wr_s;
      collision_r <= coll_s;
      if (wr_s) begin
        z_r    <= wr_data_s;
        zsel_r <= wr_sel_s;
      end
    end
  end

  assign sreg      = sreg_r;
  assign dreg      = dreg_r;
  assign b_flag    = b_flag_r;
  assign z         = z_r;
  assign zsel      = zsel_r;
  assign enable    = enable_r;
  assign collision = collision_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_fig_04b_block_075_reg_select.sv
// Self-checking bench: directed scenarios with fixed expectations plus a randomized run
// compared every cycle against a byte-counting behavioural model.
module tb_fig_04b_block_075_reg_select;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        alt_mem = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        result_valid = 1'b0;
  logic [15:0] result = 16'h0000;
  logic [15:0] rs_data = 16'h0000;
  logic [3:0]  src_sel, sreg, dreg, zsel;
  logic        b_flag, enable, busy, collision;
  logic [15:0] z;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [3:0]  m_sreg = 4'd0, m_dreg = 4'd0, m_wb = 4'd0, m_imm = 4'd0;
  logic        m_b = 1'b0, m_iwt = 1'b0;
  int          m_need = 0;
  logic [7:0]  m_lo = 8'd0;
  logic [15:0] e_z = 16'd0;
  logic [3:0]  e_zsel = 4'd0;
  logic        e_en = 1'b0, e_coll = 1'b0, e_busy = 1'b0;

  fig_04b_block_075_reg_select dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode), .alt_mem(alt_mem),
    .byte_valid(byte_valid), .byte_in(byte_in), .result_valid(result_valid), .result(result),
    .rs_data(rs_data), .src_sel(src_sel), .sreg(sreg), .dreg(dreg), .b_flag(b_flag),
    .z(z), .zsel(zsel), .enable(enable), .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_src();
    if (op_valid && opcode[7:4] == 4'hB && m_b) return opcode[3:0];
    return m_sreg;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic        cand;
    logic [3:0]  cand_i, old_wb, n;
    logic [15:0] cand_v;
    logic        is_imm;
    cand = 1'b0; cand_i = 4'd0; cand_v = 16'd0; old_wb = m_wb; n = opcode[3:0];
    if (!reset) begin
      m_sreg = 4'd0; m_dreg = 4'd0; m_b = 1'b0; m_wb = 4'd0; m_need = 0;
      e_z = 16'd0; e_zsel = 4'd0; e_en = 1'b0; e_coll = 1'b0; e_busy = 1'b0;
      return;
    end
    if (m_need > 0) begin
      if (byte_valid) begin
        if (m_need == 2) begin
          m_lo = byte_in; m_need = 1;
        end else begin
          cand = 1'b1; cand_i = m_imm; m_need = 0;
          cand_v = m_iwt ? {byte_in, m_lo} : {{8{byte_in[7]}}, byte_in};
        end
      end
    end else if (op_valid) begin
      is_imm = (opcode[7:4] == 4'hA || opcode[7:4] == 4'hF) && !alt_mem;
      if (opcode[7:4] == 4'h1 && !m_b) m_dreg = n;
      else if (opcode[7:4] == 4'hB && !m_b) m_sreg = n;
      else if (opcode[7:4] == 4'h2) begin m_sreg = n; m_dreg = n; m_b = 1'b1; end
      else begin
        if (opcode[7:4] == 4'h1) begin cand = 1'b1; cand_i = n; cand_v = rs_data; end
        else if (opcode[7:4] == 4'hB) begin cand = 1'b1; cand_i = m_dreg; cand_v = rs_data; end
        else if (is_imm) begin m_imm = n; m_iwt = (opcode[7:4] == 4'hF); m_need = m_iwt ? 2 : 1; end
        else m_wb = m_dreg;
        m_sreg = 4'd0; m_dreg = 4'd0; m_b = 1'b0;
      end
    end
    e_en = result_valid || cand;
    e_coll = result_valid && cand;
    if (result_valid) begin e_z = result; e_zsel = old_wb; end
    else if (cand) begin e_z = cand_v; e_zsel = cand_i; end
    e_busy = (m_need != 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    op_valid = 1'b0; byte_valid = 1'b0; result_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    checks++; if ({enable, busy, collision, zsel, z} !== 23'd0) begin errors++; $display("FAIL reset_out got %h want 0", {enable, busy, collision, zsel, z}); end
    checks++; if ({sreg, dreg, b_flag} !== 9'd0) begin errors++; $display("FAIL reset_prefix got %h want 0", {sreg, dreg, b_flag}); end
    result_valid = 1'b1; result = 16'h1234; tick();
    checks++; if ({enable, zsel, z} !== {1'b1, 4'd0, 16'h1234}) begin errors++; $display("FAIL first_wb got %h want %h", {enable, zsel, z}, {1'b1, 4'd0, 16'h1234}); end
    tick();
    checks++; if ({enable, z} !== {1'b0, 16'h1234}) begin errors++; $display("FAIL wb_hold got %h want %h", {enable, z}, {1'b0, 16'h1234}); end
  endtask

  task automatic test_with_alu();
    op_valid = 1'b1; opcode = 8'h23; tick();
    checks++; if ({sreg, dreg, b_flag} !== {4'd3, 4'd3, 1'b1}) begin errors++; $display("FAIL with_prefix got %h want %h", {sreg, dreg, b_flag}, {4'd3, 4'd3, 1'b1}); end
    op_valid = 1'b1; opcode = 8'h50; tick();
    checks++; if ({sreg, dreg, b_flag} !== 9'd0) begin errors++; $display("FAIL alu_clear got %h want 0", {sreg, dreg, b_flag}); end
    result_valid = 1'b1; result = 16'hBEEF; tick();
    checks++; if ({enable, zsel, z} !== {1'b1, 4'd3, 16'hBEEF}) begin errors++; $display("FAIL alu_dst got %h want %h", {enable, zsel, z}, {1'b1, 4'd3, 16'hBEEF}); end
  endtask

  task automatic test_move();
    op_valid = 1'b1; opcode = 8'h22; tick();
    op_valid = 1'b1; opcode = 8'h17; rs_data = 16'h00AA; tick();
    checks++; if ({enable, zsel, z, b_flag} !== {1'b1, 4'd7, 16'h00AA, 1'b0}) begin errors++; $display("FAIL move got %h want %h", {enable, zsel, z, b_flag}, {1'b1, 4'd7, 16'h00AA, 1'b0}); end
    op_valid = 1'b1; opcode = 8'h22; tick();
    checks++; if (src_sel !== 4'd2) begin errors++; $display("FAIL src_sreg got %h want 2", src_sel); end
    op_valid = 1'b1; opcode = 8'hB9; rs_data = 16'h5A5A; #1;
    checks++; if (src_sel !== 4'd9) begin errors++; $display("FAIL moves_src got %h want 9", src_sel); end
    tick();
    checks++; if ({enable, zsel, z} !== {1'b1, 4'd2, 16'h5A5A}) begin errors++; $display("FAIL moves got %h want %h", {enable, zsel, z}, {1'b1, 4'd2, 16'h5A5A}); end
  endtask

  task automatic test_iwt();
    op_valid = 1'b1; opcode = 8'hF5; tick();
    checks++; if ({busy, enable} !== 2'b10) begin errors++; $display("FAIL iwt_busy got %b want 10", {busy, enable}); end
    tick();
    byte_valid = 1'b1; byte_in = 8'h34; tick();
    checks++; if ({busy, enable} !== 2'b10) begin errors++; $display("FAIL iwt_lo got %b want 10", {busy, enable}); end
    op_valid = 1'b1; opcode = 8'h25; tick();
    tick();
    byte_valid = 1'b1; byte_in = 8'h12; tick();
    checks++; if ({enable, busy, zsel, z} !== {1'b1, 1'b0, 4'd5, 16'h1234}) begin errors++; $display("FAIL iwt_done got %h want %h", {enable, busy, zsel, z}, {1'b1, 1'b0, 4'd5, 16'h1234}); end
    checks++; if ({sreg, b_flag} !== 5'd0) begin errors++; $display("FAIL iwt_ignore got %h want 0", {sreg, b_flag}); end
  endtask

  task automatic test_ibt();
    op_valid = 1'b1; opcode = 8'hA9; tick();
    byte_valid = 1'b1; byte_in = 8'h80; tick();
    checks++; if ({enable, zsel, z} !== {1'b1, 4'd9, 16'hFF80}) begin errors++; $display("FAIL ibt got %h want %h", {enable, zsel, z}, {1'b1, 4'd9, 16'hFF80}); end
    alt_mem = 1'b1; op_valid = 1'b1; opcode = 8'hA9; tick(); alt_mem = 1'b0;
    checks++; if ({busy, enable} !== 2'b00) begin errors++; $display("FAIL alt_mem got %b want 00", {busy, enable}); end
    byte_valid = 1'b1; byte_in = 8'h11; tick();
    checks++; if ({busy, enable} !== 2'b00) begin errors++; $display("FAIL idle_byte got %b want 00", {busy, enable}); end
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; opcode = 8'hF3; tick();
    byte_valid = 1'b1; byte_in = 8'h77; tick();
    reset = 1'b0; tick(); reset = 1'b1;
    checks++; if ({busy, enable} !== 2'b00) begin errors++; $display("FAIL rst_mid got %b want 00", {busy, enable}); end
    byte_valid = 1'b1; byte_in = 8'h11; tick();
    checks++; if ({busy, enable} !== 2'b00) begin errors++; $display("FAIL rst_discard got %b want 00", {busy, enable}); end
  endtask

  task automatic test_collision();
    op_valid = 1'b1; opcode = 8'h24; tick();
    op_valid = 1'b1; opcode = 8'h50; tick();
    op_valid = 1'b1; opcode = 8'h22; tick();
    op_valid = 1'b1; opcode = 8'h16; rs_data = 16'hAAAA;
    result_valid = 1'b1; result = 16'h0F0F; tick();
    checks++; if ({enable, collision, zsel, z} !== {1'b1, 1'b1, 4'd4, 16'h0F0F}) begin errors++; $display("FAIL coll_move got %h want %h", {enable, collision, zsel, z}, {1'b1, 1'b1, 4'd4, 16'h0F0F}); end
    checks++; if (b_flag !== 1'b0) begin errors++; $display("FAIL coll_prefix got %b want 0", b_flag); end
    tick();
    checks++; if ({enable, collision} !== 2'b00) begin errors++; $display("FAIL coll_pulse got %b want 00", {enable, collision}); end
    op_valid = 1'b1; opcode = 8'hA7; tick();
    byte_valid = 1'b1; byte_in = 8'h05; result_valid = 1'b1; result = 16'h9999; tick();
    checks++; if ({enable, collision, busy, zsel, z} !== {1'b1, 1'b1, 1'b0, 4'd4, 16'h9999}) begin errors++; $display("FAIL coll_imm got %h want %h", {enable, collision, busy, zsel, z}, {1'b1, 1'b1, 1'b0, 4'd4, 16'h9999}); end
  endtask

  task automatic test_random();
    logic [3:0] his [6];
    his[0] = 4'h1; his[1] = 4'h2; his[2] = 4'hB; his[3] = 4'hA; his[4] = 4'hF; his[5] = 4'h0;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 59) != 0);
      op_valid     = ($urandom_range(0, 2) == 0);
      opcode       = {his[$urandom_range(0, 5)], 4'($urandom_range(0, 15))};
      if (opcode[7:4] == 4'h0) opcode[7:4] = 4'($urandom_range(0, 15));
      alt_mem      = ($urandom_range(0, 3) == 0);
      byte_valid   = ($urandom_range(0, 2) == 0);
      byte_in      = 8'($urandom);
      result_valid = ($urandom_range(0, 4) == 0);
      result       = 16'($urandom);
      rs_data      = 16'($urandom);
      #1;
      checks++; if (src_sel !== model_src()) begin errors++; $display("FAIL rnd_src cyc %0d got %h want %h", i, src_sel, model_src()); end
      tick();
      checks++; if ({sreg, dreg, b_flag} !== {m_sreg, m_dreg, m_b}) begin errors++; $display("FAIL rnd_prefix cyc %0d got %h want %h", i, {sreg, dreg, b_flag}, {m_sreg, m_dreg, m_b}); end
      checks++; if ({enable, collision, busy} !== {e_en, e_coll, e_busy}) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %b want %b", i, {enable, collision, busy}, {e_en, e_coll, e_busy}); end
      checks++; if ({zsel, z} !== {e_zsel, e_z}) begin errors++; $display("FAIL rnd_wdata cyc %0d got %h want %h", i, {zsel, z}, {e_zsel, e_z}); end
    end
    reset = 1'b1; alt_mem = 1'b0;
  endtask

  initial begin
    test_reset();
    test_with_alu();
    test_move();
    test_iwt();
    test_ibt();
    test_reset_mid();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fig_04b_block_075_reg_select.md
# fig_04b_block_075_reg_select

Register-destination/source selector and writeback sequencer sitting directly upstream of the 16-entry register file. It tracks the SuperFX prefix state (Sreg, Dreg, B flag) from decoded opcodes and resolves MOVE/MOVES aliases of TO/FROM. It assembles IBT/IWT immediates from the byte stream and produces the register file's single-port write (`z`, `zsel`, `enable`). All writes are registered; there is one write per cycle at most.

## Interface
- none (no parameters)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `op_valid`  in  1  `opcode` valid this cycle (one-cycle pulse per instruction)
- `opcode`  in  8  fetched opcode byte
- `alt_mem`  in  1  ALT1/ALT2 active: 0xAn/0xFn are not immediate loads
- `byte_valid`  in  1  `byte_in` holds an operand byte this cycle
- `byte_in`  in  8  immediate operand byte
- `result_valid`  in  1  ALU result for last ordinary instruction valid
- `result`  in  16  ALU result
- `rs_data`  in  16  register-file read of `src_sel`, combinational same cycle
- `src_sel`  out  4  combinational source select to the read mux
- `sreg`, `dreg`  out  4 each  current prefix registers
- `b_flag`  out  1  WITH-prefix flag
- `z`  out  16  write data to register file
- `zsel`  out  4  write index
- `enable`  out  1  write strobe, one cycle
- `busy`  out  1  immediate load in progress; `op_valid` ignored
- `collision`  out  1  one-cycle pulse: write-producing op dropped

## Operation
- Reset values: `sreg`=0, `dreg`=0, `b_flag`=0, `z`=0, `zsel`=0, `enable`=0, `busy`=0, `collision`=0, internal `wb_dst`=0, FSM=IDLE.
- `src_sel` = `opcode[3:0]` when `op_valid` & `opcode[7:4]`=0xB & `b_flag`; else `sreg`.
- Opcode decode (accepted only when `op_valid` & FSM=IDLE), n=`opcode[3:0]`:
  - 0x1n, `b_flag`=0 (TO): `dreg`<=n.
  - 0x1n, `b_flag`=1 (MOVE): write R[n]<=`rs_data`; clear prefixes.
  - 0x2n (WITH): `sreg`<=n, `dreg`<=n, `b_flag`<=1.
  - 0xBn, `b_flag`=0 (FROM): `sreg`<=n.
  - 0xBn, `b_flag`=1 (MOVES): write R[`dreg`]<=`rs_data` (src_sel=n); clear prefixes.
  - 0xAn, `alt_mem`=0 (IBT): `imm_dst`<=n, clear prefixes, go IMM_LO (ibt).
  - 0xFn, `alt_mem`=0 (IWT): `imm_dst`<=n, clear prefixes, go IMM_LO (iwt).
  - anything else: `wb_dst`<=`dreg`, clear prefixes.
- Clear prefixes = `sreg`<=0, `dreg`<=0, `b_flag`<=0.
- FSM: IDLE; IMM_LO: on `byte_valid`, IBT writes R[imm_dst]<={{8{b[7]}},b} -> IDLE; IWT latches lo -> IMM_HI. IMM_HI: on `byte_valid` write R[imm_dst]<={b,lo} -> IDLE. `byte_valid` in IDLE ignored.
- `result_valid` (any state): write R[`wb_dst`]<=`result`, using `wb_dst` as held before this edge.
- Write priority in one cycle: `result_valid` > immediate completion > MOVE/MOVES. Loser write dropped, `collision` pulses next cycle; dropped op still updates prefix state; a dropped immediate completion still returns FSM to IDLE.
- R15 (PC) writes use the same path; no special handling.

## Timing
- Prefix update: `op_valid` at cycle N -> new `sreg/dreg/b_flag` visible N+1.
- MOVE/MOVES: `op_valid` at N (rs_data sampled N) -> `enable`=1, `zsel`, `z` at N+1.
- ALU writeback: `result_valid` at N -> `enable` at N+1.
- IBT: op at N, byte at M>N -> `enable` at M+1. IWT: lo at M, hi at K>M -> `enable` at K+1.
- `busy`=1 from N+1 through completing-byte cycle; 0 in cycle `enable` asserts.
- `enable` single cycle; `z`/`zsel` hold last value when `enable`=0.
- `reset` low mid-immediate: next cycle IDLE, `busy`=0, no write, partial byte discarded.

## Test plan
- Reset, then `result_valid`, `result`=0x1234 -> cycle after: `enable`=1, `zsel`=0, `z`=0x1234; all prefix outputs 0.
- `op` 0x23 (WITH R3), `op` 0x50, `result_valid` 0xBEEF -> `zsel`=3, `z`=0xBEEF; `b_flag` 0 after 0x50.
- `op` 0x22, `op` 0x17 with `rs_data`=0x00AA -> `enable` next cycle, `zsel`=7, `z`=0x00AA, `b_flag`=0; `op` 0x22, `op` 0xB9 -> `src_sel`=9 that cycle, `zsel`=2.
- `op` 0xF5, bytes 0x34, 0x12 with idle gaps, `op_valid` 0x25 while busy -> `zsel`=5, `z`=0x1234; `sreg` stays 0.
- `op` 0xA9, byte 0x80 -> `z`=0xFF80, `zsel`=9; `alt_mem`=1 with 0xA9 -> no busy, no write.
- IWT with `reset` low after lo byte -> no `enable`, `busy`=0; MOVE coinciding with `result_valid` -> result written, `collision` pulses once.
